// File: rtl/svm_feature_feeder.sv
// Serial feature collector for kernel_svm: assembles framed beats into
// features_flat, issues one input_valid per frame and waits for the result.
module svm_feature_feeder #(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_FEATURES   = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               feat_valid,
    output logic                               feat_ready,
    input  logic [DATA_WIDTH-1:0]              feat_data,
    input  logic                               feat_last,
    output logic                               input_valid,
    output logic [DATA_WIDTH*NUM_FEATURES-1:0] features_flat,
    input  logic                               svm_output_valid,
    output logic                               busy,
    output logic                               frame_error,
    output logic                               timeout,
    output logic [15:0]                        frame_count
);

    localparam int IW = (NUM_FEATURES > 2) ? $clog2(NUM_FEATURES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_FEATURES - 1);

    typedef enum logic [1:0] {
        S_COLLECT,
        S_DROP,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            err_q, err_d;
    logic            to_q, to_d;
    logic [15:0]     cnt_q;
    logic            cnt_inc;
    logic            wr_en;
    logic            accept;
    logic            expire;

    logic [DATA_WIDTH-1:0] slot_q [NUM_FEATURES];

    assign feat_ready  = (state_q == S_COLLECT) || (state_q == S_DROP);
    assign input_valid = (state_q == S_ISSUE);
    assign busy        = (state_q == S_WAIT);
    assign frame_error = err_q;
    assign timeout     = to_q;
    assign frame_count = cnt_q;
    assign accept      = feat_valid & feat_ready;

    // Fires on the edge where the timer would reach TIMEOUT_CYCLES-1, so the
    // timeout pulse lands TIMEOUT_CYCLES cycles after the input_valid pulse.
    assign expire = (32'(timer_q) + 32'd2) >= 32'(TIMEOUT_CYCLES);

    genvar g;
    generate
        for (g = 0; g < NUM_FEATURES; g++) begin : g_flat
            assign features_flat[(g+1)*DATA_WIDTH-1 -: DATA_WIDTH] = slot_q[g];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        err_d   = 1'b0;
        to_d    = 1'b0;
        cnt_inc = 1'b0;
        wr_en   = 1'b0;
        unique case (state_q)
            S_COLLECT: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        err_d   = ~feat_last;
                        state_d = feat_last ? S_ISSUE : S_DROP;
                    end else if (feat_last) begin
                        idx_d = '0;
                        err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_DROP: begin
                if (accept && feat_last) begin
                    state_d = S_COLLECT;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                timer_d = '0;
            end
            S_WAIT: begin
                if (svm_output_valid) begin
                    cnt_inc = 1'b1;
                    state_d = S_COLLECT;
                end else if (expire) begin
                    to_d    = 1'b1;
                    state_d = S_COLLECT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_COLLECT;
            idx_q   <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            to_q    <= to_d;
            if (cnt_inc) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FEATURES; i++) begin
                slot_q[i] <= '0;
            end
        end else if (wr_en) begin
            slot_q[idx_q] <= feat_data;
        end
    end

endmodule
